alu_pipe: RTL and testbench

- Parametrised, pipelined fixed-point ALU for the autoencoder datapath; the successor to the combinational 16-bit add/sub/mult unit.
- Adds generic width and fraction point, plus valid/ready handshakes on input and output.
- Adds a multiply-accumulate mode with an internal accumulator and overflow detection.
- Sits between the weight/activation fetch logic and the layer result buffers; one operation accepted per cycle.

---
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined signed fixed-point ALU: ADD/SUB/MUL/MAC/CLR_ACC; saturating overflow when ALU_SAT_EN is defined, wrapping otherwise.
// Latency 2 cycles (S1 operand/product register, S2 output register), 1 op/cycle.
// Backpressure: both stages advance only when the output is empty or taken; in_ready follows out_ready combinationally.
module alu_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [2:0]        op_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_MAC = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;

`ifdef ALU_SAT_EN
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    logic                       advance;
    logic signed [2*DATA_W-1:0] prod_raw;

    logic                       s1_vld;
    logic [2:0]                 s1_op;
    logic [DATA_W-1:0]          s1_a;
    logic [DATA_W-1:0]          s1_b;
    logic [2*DATA_W-1:0]        s1_prod;
    logic [DATA_W-1:0]          acc;

    logic [DATA_W:0]            sum_ext;
    logic [DATA_W:0]            acc_ext;
    logic [DATA_W-1:0]          sum_fix;
    logic [DATA_W-1:0]          prod_fix;
    logic [DATA_W-1:0]          acc_fix;
    logic                       sum_ovf;
    logic                       prod_ovf;
    logic                       acc_ovf;
    logic [DATA_W-1:0]          nxt_res;
    logic                       nxt_ovf;
    logic                       nxt_err;
    logic                       acc_wr;
    logic [DATA_W-1:0]          acc_nxt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign prod_raw = $signed(op_a) * $signed(op_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_op   <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_prod <= '0;
        end else if (advance) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_op   <= op_sel;
                s1_a    <= op_a;
                s1_b    <= op_b;
                s1_prod <= prod_raw >>> FRAC_W;
            end
        end
    end

    always_comb begin
        sum_ext = '0;
        if (s1_op == OP_SUB)
            sum_ext = {s1_a[DATA_W-1], s1_a} - {s1_b[DATA_W-1], s1_b};
        else
            sum_ext = {s1_a[DATA_W-1], s1_a} + {s1_b[DATA_W-1], s1_b};
        sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
        // Shifted product fits only if every bit above the result sign bit matches it.
        prod_ovf = !((&s1_prod[2*DATA_W-1:DATA_W-1]) || !(|s1_prod[2*DATA_W-1:DATA_W-1]));
`ifdef ALU_SAT_EN
        sum_fix  = sum_ovf  ? (sum_ext[DATA_W]       ? MIN_V : MAX_V) : sum_ext[DATA_W-1:0];
        prod_fix = prod_ovf ? (s1_prod[2*DATA_W-1]   ? MIN_V : MAX_V) : s1_prod[DATA_W-1:0];
`else
        sum_fix  = sum_ext[DATA_W-1:0];
        prod_fix = s1_prod[DATA_W-1:0];
`endif
        acc_ext = {acc[DATA_W-1], acc} + {prod_fix[DATA_W-1], prod_fix};
        acc_ovf = acc_ext[DATA_W] ^ acc_ext[DATA_W-1];
`ifdef ALU_SAT_EN
        acc_fix = acc_ovf ? (acc_ext[DATA_W] ? MIN_V : MAX_V) : acc_ext[DATA_W-1:0];
`else
        acc_fix = acc_ext[DATA_W-1:0];
`endif

        nxt_res = '0;
        nxt_ovf = 1'b0;
        nxt_err = 1'b0;
        acc_wr  = 1'b0;
        acc_nxt = '0;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                nxt_res = sum_fix;
                nxt_ovf = sum_ovf;
            end
            OP_MUL: begin
                nxt_res = prod_fix;
                nxt_ovf = prod_ovf;
            end
            OP_MAC: begin
                nxt_res = acc_fix;
                nxt_ovf = prod_ovf | acc_ovf;
                acc_wr  = 1'b1;
                acc_nxt = acc_fix;
            end
            OP_CLR: begin
                acc_wr  = 1'b1;
            end
            default: begin
                nxt_err = 1'b1;
            end
        endcase
    end

    // The accumulator is only written here, so back-to-back MACs see each other in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                result <= nxt_res;
                ovf    <= nxt_ovf;
                err    <= nxt_err;
                if (acc_wr)
                    acc <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: spec vector table, latency/backpressure/reset sequences, randomized traffic vs integer model.
module tb_alu_pipe;

    localparam int DW = 16;
    localparam int FW = 8;

`ifdef ALU_SAT_EN
    localparam logic [15:0] ADD_OVF_R = 16'h7FFF;
    localparam logic [15:0] MUL_OVF_R = 16'h7FFF;
`else
    localparam logic [15:0] ADD_OVF_R = 16'h9000;
    localparam logic [15:0] MUL_OVF_R = 16'h0000;
`endif

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        ovf;
    logic        err;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    exp_t exp_q[$];
    longint acc_m = 0;

    alu_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Bring an exact integer into DATA_W range: flag overflow, clamp or keep low bits.
    function automatic logic [15:0] fit(input longint v, output logic o);
        longint mx;
        longint mn;
        logic [63:0] bits;
        mx = (longint'(1) <<< (DW-1)) - 1;
        mn = -(longint'(1) <<< (DW-1));
        o = (v > mx) || (v < mn);
        bits = v;
`ifdef ALU_SAT_EN
        if (v > mx) return 16'h7FFF;
        if (v < mn) return 16'h8000;
`endif
        return bits[15:0];
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        longint sa;
        longint sb;
        longint p;
        logic o1;
        logic o2;
        logic [15:0] pf;
        logic [15:0] na;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = (sa * sb) >>> FW;
        e.res = '0; e.ovf = 1'b0; e.err = 1'b0;
        case (op)
            3'd0: e.res = fit(sa + sb, e.ovf);
            3'd1: e.res = fit(sa - sb, e.ovf);
            3'd2: e.res = fit(p, e.ovf);
            3'd3: begin
                pf = fit(p, o1);
                na = fit(acc_m + longint'($signed(pf)), o2);
                acc_m = longint'($signed(na));
                e.res = na;
                e.ovf = o1 | o2;
            end
            3'd4: acc_m = 0;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Holds the operation until accepted; queues the table value or the model value.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic use_tab, input exp_t te);
        exp_t e;
        logic got;
        got = 1'b0;
        op_sel = op; op_a = a; op_b = b; in_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            e = model(op, a, b);
            exp_q.push_back(use_tab ? te : e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard on transfers, stability and in_ready during stalls.
    logic        stall_prev = 1'b0;
    logic [15:0] h_res;
    logic        h_ovf;
    logic        h_err;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_result_stable", result, h_res);
                check("stall_ovf_stable", ovf, h_ovf);
                check("stall_err_stable", err, h_err);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 32'd0);
                stall_prev = 1'b1;
                stall_cnt++;
                h_res = result; h_ovf = ovf; h_err = err;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("ovf", ovf, e.ovf);
                    check("err", err, e.err);
                end
            end
        end
    end

    vec_t vecs[14];
    exp_t none;

    initial begin
        int s0;
        logic seen;
        logic done;
        none = '{res: 16'h0, ovf: 1'b0, err: 1'b0};
        vecs[0]  = '{3'd4, 16'h0000, 16'h0000, '{16'h0000, 1'b0, 1'b0}};
        vecs[1]  = '{3'd2, 16'h0180, 16'h0200, '{16'h0300, 1'b0, 1'b0}};
        vecs[2]  = '{3'd1, 16'h0100, 16'h0300, '{16'hFE00, 1'b0, 1'b0}};
        vecs[3]  = '{3'd0, 16'h0100, 16'h0080, '{16'h0180, 1'b0, 1'b0}};
        vecs[4]  = '{3'd0, 16'h7000, 16'h2000, '{ADD_OVF_R, 1'b1, 1'b0}};
        vecs[5]  = '{3'd2, 16'h4000, 16'h0400, '{MUL_OVF_R, 1'b1, 1'b0}};
        vecs[6]  = '{3'd4, 16'h1234, 16'h5678, '{16'h0000, 1'b0, 1'b0}};
        vecs[7]  = '{3'd3, 16'h0100, 16'h0200, '{16'h0200, 1'b0, 1'b0}};
        vecs[8]  = '{3'd3, 16'h0080, 16'h0400, '{16'h0400, 1'b0, 1'b0}};
        vecs[9]  = '{3'd3, 16'hFF00, 16'h0100, '{16'h0300, 1'b0, 1'b0}};
        vecs[10] = '{3'd0, 16'h0001, 16'h0001, '{16'h0002, 1'b0, 1'b0}};
        vecs[11] = '{3'd3, 16'h0000, 16'h0000, '{16'h0300, 1'b0, 1'b0}};
        vecs[12] = '{3'd7, 16'h0100, 16'h0100, '{16'h0000, 1'b0, 1'b1}};
        vecs[13] = '{3'd3, 16'h0100, 16'h0100, '{16'h0400, 1'b0, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; out_ready = 1'b1;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);

        // Two-cycle latency on an empty pipe.
        send(3'd2, 16'h0180, 16'h0200, 1'b1, '{16'h0300, 1'b0, 1'b0});
        check("lat_cycle1_valid", out_valid, 32'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", out_valid, 32'd1);
        check("lat_cycle2_result", result, 32'h0300);
        drain();

        for (int i = 0; i < 14; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].e);
        drain();

        // Backpressure: out_ready low for 3 cycles once the first result appears.
        s0 = stall_cnt;
        seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(3'd0, 16'(i * 16'h0100), 16'(16'h0010 + i), 1'b0, none);
            end
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1'b1;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("bp_first_valid_seen", {31'd0, seen}, 32'd1);
        drain();
        check("bp_stall_cycles", stall_cnt - s0, 32'd3);

        // Randomized traffic with random backpressure and input gaps.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [2:0] op;
                    logic [15:0] a;
                    logic [15:0] b;
                    int r;
                    r = $urandom_range(0, 9);
                    op = (r < 8) ? 3'(r / 2) : (r == 8) ? 3'd4 : 3'($urandom_range(5, 7));
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) a = {{6{a[9]}}, a[9:0]};
                    if ($urandom_range(0, 1) == 1) b = {{6{b[9]}}, b[9:0]};
                    send(op, a, b, 1'b0, none);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two operations in flight and acc = 0x0300.
        send(3'd4, 16'h0, 16'h0, 1'b1, '{16'h0000, 1'b0, 1'b0});
        send(3'd3, 16'h0100, 16'h0300, 1'b1, '{16'h0300, 1'b0, 1'b0});
        drain();
        out_ready = 1'b0;
        send(3'd3, 16'h0100, 16'h0100, 1'b0, none);
        send(3'd0, 16'h0100, 16'h0100, 1'b0, none);
        check("inflight_valid", out_valid, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 32'd0);
        check("arst_result", result, 32'd0);
        exp_q.delete();
        acc_m = 0;
        out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_output", out_valid, 32'd0);
        send(3'd3, 16'h0100, 16'h0100, 1'b1, '{16'h0100, 1'b0, 1'b0});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
